// File: rtl/mem_stage.sv
// mem_stage: RV32I load/store unit with a three-state handshake to data memory
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        dmem_resp,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_mbe,
  output logic [31:0] mdr_out,
  output logic        stall,
  output logic        misaligned,
  output logic [3:0]  rmask,
  output logic [3:0]  wmask
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, mdr_q, mdr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        rd_q, rd_d, wr_q, wr_d, mis_q, mis_d;
  logic        req, in_mis, latch, access, done, load_q;
  logic [3:0]  mask;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  assign req      = req_valid & (mem_read | mem_write);
  assign in_mis   = funct3[1:0] == 2'b00 ? 1'b0 : funct3[1:0] == 2'b01 ? addr[0] : |addr[1:0];
  assign latch    = (state_q == IDLE) & req;
  assign access   = state_q == ACCESS;
  assign done     = state_q == DONE;
  assign load_q   = rd_q & ~wr_q;
  assign mask     = funct3_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0] :
                    funct3_q[1:0] == 2'b01 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign byte_sel = dmem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign half_sel = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
  assign load_val = funct3_q == 3'b000 ? {{24{byte_sel[7]}}, byte_sel} :
                    funct3_q == 3'b100 ? {24'b0, byte_sel} :
                    funct3_q == 3'b001 ? {{16{half_sel[15]}}, half_sel} :
                    funct3_q == 3'b101 ? {16'b0, half_sel} : dmem_rdata;
  // Memory-side outputs come from latched state so they stay stable across waits
  assign dmem_write   = access & wr_q;
  assign dmem_read    = access & load_q;
  assign dmem_address = {addr_q[31:2], 2'b00};
  assign dmem_wdata   = funct3_q[1:0] == 2'b00 ? {4{wdata_q[7:0]}} :
                        funct3_q[1:0] == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
  assign dmem_mbe     = ~access ? 4'b0000 : wr_q ? mask : 4'b1111;
  assign stall        = latch | access;
  assign misaligned   = done & mis_q;
  assign rmask        = done & ~mis_q & load_q ? mask : 4'b0000;
  assign wmask        = done & ~mis_q & wr_q ? mask : 4'b0000;
  assign mdr_out      = mdr_q;
  // Next state, request capture and load-result update
  always_comb begin
    state_d  = state_q == IDLE ? (req ? (in_mis ? DONE : ACCESS) : IDLE) :
               state_q == ACCESS ? (dmem_resp ? DONE : ACCESS) : IDLE;
    addr_d   = latch ? addr : addr_q;
    wdata_d  = latch ? wdata : wdata_q;
    funct3_d = latch ? funct3 : funct3_q;
    rd_d     = latch ? mem_read : rd_q;
    wr_d     = latch ? mem_write : wr_q;
    mis_d    = latch ? in_mis : mis_q;
    mdr_d    = access & dmem_resp & load_q ? load_val :
               latch & in_mis & ~mem_write ? 32'd0 : mdr_q;
  end
  // State register; reset abandons any in-flight access immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      mis_q    <= 1'b0;
      mdr_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      mis_q    <= mis_d;
      mdr_q    <= mdr_d;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for the load/store unit
module tb_mem_stage;
  logic        clk = 0, rst = 0, req_valid = 0, mem_read = 0, mem_write = 0, dmem_resp = 0;
  logic [2:0]  funct3 = 0;
  logic [31:0] addr = 0, wdata = 0, dmem_rdata = 0;
  logic        dmem_read, dmem_write, stall, misaligned;
  logic [31:0] dmem_address, dmem_wdata, mdr_out;
  logic [3:0]  dmem_mbe, rmask, wmask;

  mem_stage dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata), .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
    .dmem_wdata(dmem_wdata), .dmem_mbe(dmem_mbe), .mdr_out(mdr_out), .stall(stall),
    .misaligned(misaligned), .rmask(rmask), .wmask(wmask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] mdr, addr, wdata;
    logic [3:0]  mbe, rmask, wmask;
    logic        mis, rd, wr;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_cmp = 0, n_bad = 0;
  logic [31:0] mdr_model = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic predict(input bit r, input bit w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rdat, output exp_t e);
    logic [3:0]  m;
    logic [31:0] wdx, b, h;
    case (f3[1:0])
      2'b00:   begin m = 4'b0001 << a[1:0]; wdx = {4{wd[7:0]}}; e.mis = 1'b0; end
      2'b01:   begin m = a[1] ? 4'b1100 : 4'b0011; wdx = {2{wd[15:0]}}; e.mis = a[0]; end
      default: begin m = 4'b1111; wdx = wd; e.mis = a[1:0] != 2'b00; end
    endcase
    e.addr  = a & 32'hFFFF_FFFC;
    e.wr    = w;
    e.rd    = r & ~w;
    e.mbe   = w ? m : 4'b1111;
    e.wdata = wdx;
    e.rmask = (!w && !e.mis) ? m : 4'b0000;
    e.wmask = (w && !e.mis) ? m : 4'b0000;
    b = rdat >> (8 * a[1:0]);
    h = rdat >> (16 * a[1]);
    if (!w) begin
      if (e.mis) mdr_model = 32'd0;
      else case (f3)
        3'b000:  mdr_model = {{24{b[7]}}, b[7:0]};
        3'b100:  mdr_model = {24'd0, b[7:0]};
        3'b001:  mdr_model = {{16{h[15]}}, h[15:0]};
        3'b101:  mdr_model = {16'd0, h[15:0]};
        default: mdr_model = rdat;
      endcase
    end
    e.mdr = mdr_model;
  endtask

  // Monitor: memory-side checks during accesses, result checks on completion
  always @(negedge clk) begin
    if (!rst) begin
      if (dmem_read | dmem_write) begin
        if (sb_q.size() == 0) chk("spurious_access", 1, 0);
        else begin
          chk("mis_no_access", {31'd0, sb_q[0].mis}, 0);
          chk("dmem_address", dmem_address, sb_q[0].addr);
          chk("dmem_mbe", {28'd0, dmem_mbe}, {28'd0, sb_q[0].mbe});
          chk("dmem_read", {31'd0, dmem_read}, {31'd0, sb_q[0].rd});
          chk("dmem_write", {31'd0, dmem_write}, {31'd0, sb_q[0].wr});
          if (sb_q[0].wr) chk("dmem_wdata", dmem_wdata, sb_q[0].wdata);
        end
      end
      if (misaligned || rmask != 0 || wmask != 0) begin
        if (sb_q.size() == 0) chk("spurious_done", 1, 0);
        else begin
          mon_e = sb_q.pop_front();
          chk("mdr_out", mdr_out, mon_e.mdr);
          chk("rmask", {28'd0, rmask}, {28'd0, mon_e.rmask});
          chk("wmask", {28'd0, wmask}, {28'd0, mon_e.wmask});
          chk("misaligned", {31'd0, misaligned}, {31'd0, mon_e.mis});
        end
      end
    end
  end

  // Drives one request and the memory response; returns at the negedge inside DONE
  task automatic issue(input bit r, input bit w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rdat, input int nwait, input bit b2b);
    exp_t e;
    if (!b2b) @(negedge clk);
    req_valid = 1; mem_read = r; mem_write = w; funct3 = f3; addr = a; wdata = wd; dmem_rdata = rdat;
    predict(r, w, f3, a, wd, rdat, e);
    sb_q.push_back(e);
    #1;
    if (b2b) begin
      chk("stall_done_req", {31'd0, stall}, 0);
      chk("read_done_req", {31'd0, dmem_read}, 0);
      @(negedge clk); #1;
    end
    chk("stall_idle", {31'd0, stall}, 1);
    chk("read_idle", {31'd0, dmem_read | dmem_write}, 0);
    if (!e.mis) begin
      repeat (nwait) begin @(negedge clk); #1 chk("stall_wait", {31'd0, stall}, 1); end
      @(negedge clk); dmem_resp = 1; #1 chk("stall_resp", {31'd0, stall}, 1);
    end
    @(negedge clk); dmem_resp = 0; #1 chk("stall_fin", {31'd0, stall}, 0);
    req_valid = 0;
  endtask

  initial begin
    #1 rst = 1;
    #2;
    chk("rst_mdr", mdr_out, 0);
    chk("rst_addr", dmem_address, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_ctl", {24'd0, dmem_read, dmem_write, misaligned, stall, dmem_mbe}, 0);
    chk("rst_masks", {24'd0, rmask, wmask}, 0);
    @(negedge clk); rst = 0;
    issue(1, 0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_FF12, 3, 0);
    issue(0, 1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 0, 0);
    issue(1, 0, 3'b010, 32'h0000_3001, 32'h0, 32'h1111_1111, 0, 0);
    issue(1, 0, 3'b101, 32'h0000_4002, 32'h0, 32'h8001_0000, 1, 0);
    issue(0, 1, 3'b000, 32'h0000_4001, 32'h0000_005A, 32'h0, 0, 1);
    issue(1, 0, 3'b001, 32'h0000_6002, 32'h0, 32'h9234_0000, 0, 0);
    issue(1, 0, 3'b100, 32'h0000_7001, 32'h0, 32'h0000_C300, 2, 0);
    issue(0, 1, 3'b010, 32'h0000_8000, 32'hDEAD_BEEF, 32'h0, 2, 0);
    issue(0, 1, 3'b001, 32'h0000_9001, 32'h1234_5678, 32'h0, 0, 0);
    issue(1, 0, 3'b110, 32'h0000_A004, 32'h0, 32'h1234_5678, 0, 0);
    issue(1, 1, 3'b010, 32'h0000_C008, 32'hCAFE_F00D, 32'h0, 1, 0);
    issue(1, 0, 3'b001, 32'h0000_B003, 32'h0, 32'hFFFF_FFFF, 0, 0);
    issue(1, 0, 3'b000, 32'h0000_D002, 32'h0, 32'h0055_0000, 0, 0);
    @(negedge clk); dmem_resp = 1; dmem_rdata = 32'hFFFF_FFFF;
    #1 chk("idle_resp_stall", {31'd0, stall}, 0);
    @(negedge clk); dmem_resp = 0;
    #1 chk("idle_resp_mdr", mdr_out, mdr_model);
    @(negedge clk);
    req_valid = 1; mem_read = 1; mem_write = 0; funct3 = 3'b010; addr = 32'h0000_5000;
    dmem_rdata = 32'h7777_7777;
    begin exp_t e; predict(1, 0, 3'b010, 32'h0000_5000, 32'h0, 32'h7777_7777, e); sb_q.push_back(e); end
    @(negedge clk); #1 chk("rst_acc_read", {31'd0, dmem_read}, 1);
    #2 rst = 1; req_valid = 0;
    #1;
    chk("rst_async_read", {31'd0, dmem_read}, 0);
    chk("rst_async_mbe", {28'd0, dmem_mbe}, 0);
    chk("rst_async_mdr", mdr_out, 0);
    chk("rst_async_stall", {31'd0, stall}, 0);
    sb_q.delete();
    mdr_model = 0;
    @(negedge clk); rst = 0; dmem_resp = 1;
    #1 chk("post_rst_read", {31'd0, dmem_read}, 0);
    @(negedge clk); dmem_resp = 0;
    #1 chk("post_rst_mdr", mdr_out, 0);
    chk("post_rst_done", {29'd0, misaligned, |rmask, |wmask}, 0);
    repeat (2) @(negedge clk);
    chk("queue_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
